vga_frame_sched: RTL

- Frame-level scheduler for the VGA display read path.
- Decides which DDR3 frame buffer the VGA reader fetches each frame, using triple buffering over three equal-size buffers. Issues the one-cycle start pulse plus base/length to the DDR3 read master, and gates the VGA controller's pixel-word requests into the read FIFO.
- Hands the writer (HPS or camera path) the index of the buffer it may safely overwrite next, and keeps per-frame integrity statistics.

---
 rtl/vga_frame_sched_if.sv | 28 ++
 rtl/vga_frame_sched.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/vga_frame_sched_if.sv
// Read-path bundle between the frame scheduler, the VGA timing controller's FIFO
// requests and the DDR3 read master.
interface vga_frame_sched_if;
    logic        read_req;
    logic        data_available;
    logic        read_en;
    logic [31:0] read_base;
    logic [31:0] read_length;
    logic        read_go;

    modport master (
        input  read_req,
        input  data_available,
        output read_en,
        output read_base,
        output read_length,
        output read_go
    );

    modport slave (
        output read_req,
        output data_available,
        input  read_en,
        input  read_base,
        input  read_length,
        input  read_go
    );
endinterface

// File: rtl/vga_frame_sched.sv
// Triple-buffered frame scheduler for the VGA read path.
// Define VGA_SCHED_STATS_EN to build the frame and underflow counters.
module vga_frame_sched #(
    parameter logic [31:0] BUFFER0    = 32'h3088_0000,
    parameter logic [31:0] LENGTH     = 32'h0005_DC00,
    parameter int unsigned WORD_BYTES = 16
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              enable_i,
    input  logic              single_go_i,
    input  logic              frame_start_i,
    input  logic              frame_end_i,
    input  logic              wr_done_i,
    input  logic [1:0]        wr_buf_i,
    output logic [1:0]        wr_next_o,
    output logic [1:0]        cur_buf_o,
    output logic              busy_o,
    output logic              err_short_o,
    output logic [15:0]       frame_cnt_o,
    output logic [15:0]       underflow_cnt_o,
    vga_frame_sched_if.master bus
);
    localparam int unsigned FRAME_WORDS = LENGTH / WORD_BYTES;
    localparam int unsigned CntW        = $clog2(FRAME_WORDS + 1);
    localparam logic [CntW-1:0] FrameWordsC = CntW'(FRAME_WORDS);

    typedef enum logic [1:0] {StIdle, StWaitStart, StStream} state_e;

    state_e            state_q;
    logic [1:0]        cur_buf_q;
    logic [1:0]        latest_q;
    logic              latest_valid_q;
    logic              one_shot_q;
    logic [31:0]       read_base_q;
    logic              read_go_q;
    logic              err_short_q;
    logic [CntW-1:0]   word_cnt_q;
    logic [CntW-1:0]   word_cnt_inc;
    logic [1:0]        sel;
    logic              in_stream;
    logic              words_left;
    logic              read_en;

    assign in_stream    = (state_q == StStream);
    assign words_left   = (word_cnt_q < FrameWordsC);
    assign read_en      = in_stream & bus.read_req & bus.data_available & words_left;
    assign word_cnt_inc = word_cnt_q + CntW'(read_en);
    // Selection sees latest_q before any same-cycle wr_done update.
    assign sel          = latest_valid_q ? latest_q : cur_buf_q;

    always_comb begin
        wr_next_o = 2'd2;
        if (cur_buf_q != 2'd0 && latest_q != 2'd0) begin
            wr_next_o = 2'd0;
        end else if (cur_buf_q != 2'd1 && latest_q != 2'd1) begin
            wr_next_o = 2'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            cur_buf_q      <= 2'd0;
            latest_q       <= 2'd0;
            latest_valid_q <= 1'b0;
            one_shot_q     <= 1'b0;
            read_base_q    <= BUFFER0;
            read_go_q      <= 1'b0;
            err_short_q    <= 1'b0;
            word_cnt_q     <= '0;
        end else begin
            read_go_q   <= 1'b0;
            err_short_q <= 1'b0;
            if (wr_done_i && wr_buf_i != 2'd3) begin
                latest_q       <= wr_buf_i;
                latest_valid_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (enable_i || single_go_i) begin
                        state_q    <= StWaitStart;
                        one_shot_q <= single_go_i;
                    end
                end
                StWaitStart: begin
                    if (frame_start_i) begin
                        cur_buf_q   <= sel;
                        read_base_q <= BUFFER0 + 32'(sel) * LENGTH;
                        read_go_q   <= 1'b1;
                        word_cnt_q  <= '0;
                        state_q     <= StStream;
                    end
                end
                StStream: begin
                    word_cnt_q <= word_cnt_inc;
                    // A coincident frame_start is dropped; the next frame waits in StWaitStart.
                    if (frame_end_i) begin
                        err_short_q <= (word_cnt_inc != FrameWordsC);
                        if (enable_i && !one_shot_q) begin
                            state_q <= StWaitStart;
                        end else begin
                            state_q    <= StIdle;
                            one_shot_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef VGA_SCHED_STATS_EN
    logic        frame_hit;
    logic        under_hit;
    logic [15:0] frame_cnt_q;
    logic [15:0] underflow_cnt_q;

    assign frame_hit = (state_q == StWaitStart) & frame_start_i;
    // Requests past the end of the frame are dropped, not underflows.
    assign under_hit = in_stream & bus.read_req & ~bus.data_available & words_left;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q     <= 16'd0;
            underflow_cnt_q <= 16'd0;
        end else begin
            if (frame_hit && frame_cnt_q != 16'hFFFF) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (under_hit && underflow_cnt_q != 16'hFFFF) begin
                underflow_cnt_q <= underflow_cnt_q + 16'd1;
            end
        end
    end

    assign frame_cnt_o     = frame_cnt_q;
    assign underflow_cnt_o = underflow_cnt_q;
`else
    assign frame_cnt_o     = 16'd0;
    assign underflow_cnt_o = 16'd0;
`endif

    assign cur_buf_o       = cur_buf_q;
    assign busy_o          = (state_q != StIdle);
    assign err_short_o     = err_short_q;
    assign bus.read_en     = read_en;
    assign bus.read_base   = read_base_q;
    assign bus.read_length = LENGTH;
    assign bus.read_go     = read_go_q;
endmodule
